// File: rtl/nmr_pkg.sv
// Shared types and constants for the NMR sample packer.
package nmr_pkg;

    localparam int unsigned ACC_W          = 24;
    localparam int unsigned MAX_DECIM_LOG2 = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } nmr_state_t;

    // Averaging exponents above the supported maximum saturate.
    function automatic logic [3:0] clamp_decim(input logic [3:0] k);
        return (k > 4'(MAX_DECIM_LOG2)) ? 4'(MAX_DECIM_LOG2) : k;
    endfunction

endpackage

// File: rtl/nmr_skid_fifo.sv
// Two-entry valid/ready FIFO with synchronous clear; output data reads zero when empty.
module nmr_skid_fifo #(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          in_valid_i,
    input  logic [DW-1:0] in_data_i,
    output logic          in_ready_o,
    output logic          out_valid_o,
    output logic [DW-1:0] out_data_o,
    input  logic          out_ready_i
);

    logic [DW-1:0] mem_q [2];
    logic [DW-1:0] mem_d [2];
    logic          rd_ptr_q, rd_ptr_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic [1:0]    count_q, count_d;
    logic          push, pop;

    // Pointer/count bookkeeping; a full FIFO still accepts a word when it is popped the same cycle.
    always_comb begin
        mem_d       = mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        out_valid_o = (count_q != 2'd0);
        out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;
        in_ready_o  = (count_q != 2'd2) || out_ready_i;
        push        = in_valid_i && in_ready_o;
        pop         = out_valid_o && out_ready_i;
        if (clr_i) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = in_data_i;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + 2'(push) - 2'(pop);
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/nmr_sample_packer.sv
// Averages ADC samples by 2^k, packs two 16-bit averages per 32-bit word, streams them out.
module nmr_sample_packer
    import nmr_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        acq_en_i,
    input  logic [3:0]  decim_log2_i,
    input  logic [31:0] nb_of_sample_i,
    input  logic [15:0] adc_dat_i,
    input  logic        adc_valid_i,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        done_o,
    output logic        overflow_o,
    output logic [31:0] smpl_cnt_o
);

    nmr_state_t               state_q, state_d;
    logic                     acq_prev_q, acq_prev_d;
    logic [3:0]               k_q, k_d;
    logic [31:0]              nb_q, nb_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [8:0]               sub_q, sub_d;
    logic [31:0]              smpl_q, smpl_d;
    logic [15:0]              half_q, half_d;
    logic                     half_full_q, half_full_d;
    logic [31:0]              word_q, word_d;
    logic                     push_q, push_d;
    logic                     ovf_q, ovf_d;
    logic                     done_q, done_d;

    logic signed [ACC_W-1:0]  sum;
    logic [15:0]              avg;
    logic [8:0]               target;
    logic [31:0]              smpl_inc;
    logic                     fifo_clr;
    logic                     fifo_in_ready;

    // Sequencer FSM, averaging accumulator and half-word packing.
    always_comb begin
        state_d     = state_q;
        acq_prev_d  = acq_en_i;
        k_d         = k_q;
        nb_d        = nb_q;
        acc_d       = acc_q;
        sub_d       = sub_q;
        smpl_d      = smpl_q;
        half_d      = half_q;
        half_full_d = half_full_q;
        word_d      = word_q;
        push_d      = 1'b0;
        ovf_d       = ovf_q;
        fifo_clr    = 1'b0;
        sum         = acc_q + $signed({{(ACC_W-16){adc_dat_i[15]}}, adc_dat_i});
        avg         = 16'(sum >>> k_q);
        target      = (9'd1 << k_q) - 9'd1;
        smpl_inc    = smpl_q + 32'd1;

        case (state_q)
            ST_IDLE: begin
                if (acq_en_i && !acq_prev_q) begin
                    k_d  = clamp_decim(decim_log2_i);
                    nb_d = nb_of_sample_i;
                    if (nb_of_sample_i == 32'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d     = ST_RUN;
                        acc_d       = '0;
                        sub_d       = '0;
                        smpl_d      = '0;
                        half_d      = '0;
                        half_full_d = 1'b0;
                        ovf_d       = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                if (!acq_en_i) begin
                    state_d  = ST_IDLE;
                    fifo_clr = 1'b1;
                end else if (adc_valid_i) begin
                    if (sub_q == target) begin
                        acc_d  = '0;
                        sub_d  = '0;
                        smpl_d = smpl_inc;
                        if (half_full_q) begin
                            word_d      = {avg, half_q};
                            push_d      = 1'b1;
                            half_full_d = 1'b0;
                        end else if (smpl_inc == nb_q) begin
                            word_d = {16'h0000, avg};
                            push_d = 1'b1;
                        end else begin
                            half_d      = avg;
                            half_full_d = 1'b1;
                        end
                        if (smpl_inc == nb_q) begin
                            state_d = ST_FLUSH;
                        end
                    end else begin
                        acc_d = sum;
                        sub_d = sub_q + 9'd1;
                    end
                end
            end
            ST_FLUSH: begin
                if (!acq_en_i) begin
                    state_d  = ST_IDLE;
                    fifo_clr = 1'b1;
                end else if (!push_q && !m_axis_tvalid) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!acq_en_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The pending word is pushed one cycle after formation; it is lost if the FIFO cannot take it.
        if (push_q && !fifo_in_ready && !fifo_clr) begin
            ovf_d = 1'b1;
        end
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acq_prev_q  <= 1'b1;
            k_q         <= '0;
            nb_q        <= '0;
            acc_q       <= '0;
            sub_q       <= '0;
            smpl_q      <= '0;
            half_q      <= '0;
            half_full_q <= 1'b0;
            word_q      <= '0;
            push_q      <= 1'b0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acq_prev_q  <= acq_prev_d;
            k_q         <= k_d;
            nb_q        <= nb_d;
            acc_q       <= acc_d;
            sub_q       <= sub_d;
            smpl_q      <= smpl_d;
            half_q      <= half_d;
            half_full_q <= half_full_d;
            word_q      <= word_d;
            push_q      <= push_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
        end
    end

    nmr_skid_fifo #(
        .DW (32)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (fifo_clr),
        .in_valid_i  (push_q),
        .in_data_i   (word_q),
        .in_ready_o  (fifo_in_ready),
        .out_valid_o (m_axis_tvalid),
        .out_data_o  (m_axis_tdata),
        .out_ready_i (m_axis_tready)
    );

    assign done_o     = done_q;
    assign overflow_o = ovf_q;
    assign smpl_cnt_o = smpl_q;

endmodule
